// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, reset/bubble defaults and the fetch-stage enums.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, sequential PC+4, branch target or jump target.
module pc_next
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [1:0]        sel_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] ifid_pc4_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       idx_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] btgt;
    logic [ADDR_W-1:0] jtgt;

    assign pc_plus4_o = pc_i + ADDR_W'(4);

    // Targets are relative to the instruction sitting in ID, not the one being fetched.
    assign btgt = ifid_pc4_i + {{(ADDR_W-18){imm_i[15]}}, imm_i, 2'b00};
    assign jtgt = {ifid_pc4_i[ADDR_W-1:28], idx_i, 2'b00};

    always_comb begin
        pc_next_o = pc_i;
        unique case (pc_sel_e'(sel_i))
            PC_HOLD:   pc_next_o = pc_i;
            PC_SEQ:    pc_next_o = pc_plus4_o;
            PC_BRANCH: pc_next_o = btgt;
            PC_JUMP:   pc_next_o = jtgt;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: PC sequencing, ID-driven redirects, stall and flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC[ADDR_W-1:0],
    parameter logic [31:0]       NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_imm_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_idx_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       ifid_instr_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic [5:0]        op_o,
    output logic [31:0]       fetch_cnt_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [31:0]       cnt_q, cnt_d;

    pc_sel_e           sel;
    logic              run;
    logic [ADDR_W-1:0] pc_plus4;

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .sel_i      (sel),
        .pc_i       (pc_q),
        .ifid_pc4_i (pc4_q),
        .imm_i      (branch_imm_i),
        .idx_i      (jump_idx_i),
        .pc_plus4_o (pc_plus4),
        .pc_next_o  (pc_d)
    );

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        sel     = PC_HOLD;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        // The edge that sees start_i fetches; the edge that sees it low idles.
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    run     = 1'b1;
                end
            end
            RUN: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!run) begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (stall_i) begin
            sel = PC_HOLD;
        end else if (jump_i && valid_q) begin
            sel     = PC_JUMP;
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (branch_taken_i && valid_q) begin
            sel     = PC_BRANCH;
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else begin
            sel     = PC_SEQ;
            instr_d = imem_data_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc4_o   = pc4_q;
    assign ifid_valid_o = valid_q;
    assign op_o         = opcode_of(instr_q);
    assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences, random run.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i, stall_i, branch_taken_i, jump_i;
    logic [15:0] branch_imm_i;
    logic [25:0] jump_idx_i;
    logic [31:0] imem_addr_o, imem_data_i, ifid_instr_o, ifid_pc4_o, fetch_cnt_o;
    logic        ifid_valid_o;
    logic [5:0]  op_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    fetch_unit dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_imm_i   (branch_imm_i),
        .jump_i         (jump_i),
        .jump_idx_i     (jump_idx_i),
        .imem_addr_o    (imem_addr_o),
        .imem_data_i    (imem_data_i),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc4_o     (ifid_pc4_o),
        .ifid_valid_o   (ifid_valid_o),
        .op_o           (op_o),
        .fetch_cnt_o    (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem_f(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h2008_0005;
        return (addr * 32'h9E37_79B1) + 32'h0135_7BDF;
    endfunction

    always_comb imem_data_i = imem_f(imem_addr_o);

    typedef struct {
        logic        start, stall, br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] pc, instr, pc4;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic st, input logic b, input logic [15:0] im,
                                input logic j, input logic [25:0] ix, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] p4, input logic v,
                                input logic [31:0] c);
        vec_t r;
        r.start = s; r.stall = st; r.br = b; r.imm = im; r.jmp = j; r.idx = ix;
        r.pc = pc; r.instr = ins; r.pc4 = p4; r.valid = v; r.cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        chk({tag, ".pc"}, imem_addr_o, pc);
        chk({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, valid});
        chk({tag, ".cnt"}, fetch_cnt_o, cnt);
        chk({tag, ".instr"}, ifid_instr_o, valid ? instr : 32'h0);
        chk({tag, ".op"}, {26'b0, op_o}, {26'b0, (valid ? instr[31:26] : 6'h00)});
        if (valid) chk({tag, ".pc4"}, ifid_pc4_o, pc4);
    endtask

    task automatic drive(input logic s, input logic st, input logic b, input logic [15:0] im,
                         input logic j, input logic [25:0] ix);
        start_i = s; stall_i = st; branch_taken_i = b; branch_imm_i = im;
        jump_i = j; jump_idx_i = ix;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        start_i = 0; stall_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_imm_i = '0; jump_idx_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    // Behavioural reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    task automatic model_step(input logic s, input logic st, input logic b, input logic [15:0] im,
                              input logic j, input logic [25:0] ix);
        logic [31:0] off;
        off = {{16{im[15]}}, im} * 32'd4;
        if (!s) begin
            m_instr = 32'h0; m_valid = 0; m_pc4 = 0;
        end else if (st) begin
            // nothing moves
        end else if (j && m_valid) begin
            m_pc = (m_pc4 & 32'hF000_0000) | ({6'b0, ix} * 32'd4);
            m_instr = 32'h0; m_valid = 0;
        end else if (b && m_valid) begin
            m_pc = m_pc4 + off;
            m_instr = 32'h0; m_valid = 0;
        end else begin
            m_instr = imem_f(m_pc);
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc;
            m_valid = 1;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    vec_t tbl [15];

    initial begin
        tbl[0]  = mk(1,0,0,16'h0,   0,26'h0,  32'h4,   32'h2008_0005,  32'h4,   1, 1);
        tbl[1]  = mk(1,0,0,16'h0,   0,26'h0,  32'h8,   imem_f(32'h4),  32'h8,   1, 2);
        tbl[2]  = mk(1,0,0,16'h0,   0,26'h0,  32'hC,   imem_f(32'h8),  32'hC,   1, 3);
        tbl[3]  = mk(1,0,0,16'h0,   0,26'h0,  32'h10,  imem_f(32'hC),  32'h10,  1, 4);
        tbl[4]  = mk(1,0,1,16'hFFFC,0,26'h0,  32'h0,   32'h0,          32'h0,   0, 4);
        tbl[5]  = mk(1,0,0,16'h0,   0,26'h0,  32'h4,   32'h2008_0005,  32'h4,   1, 5);
        tbl[6]  = mk(1,1,1,16'h0040,0,26'h0,  32'h4,   32'h2008_0005,  32'h4,   1, 5);
        tbl[7]  = mk(1,1,0,16'h0,   1,26'h40, 32'h4,   32'h2008_0005,  32'h4,   1, 5);
        tbl[8]  = mk(1,1,0,16'h0,   0,26'h0,  32'h4,   32'h2008_0005,  32'h4,   1, 5);
        tbl[9]  = mk(1,0,0,16'h0,   0,26'h0,  32'h8,   imem_f(32'h4),  32'h8,   1, 6);
        tbl[10] = mk(1,0,1,16'h0008,1,26'h40, 32'h100, 32'h0,          32'h0,   0, 6);
        tbl[11] = mk(1,0,0,16'h0,   1,26'h80, 32'h104, imem_f(32'h100),32'h104, 1, 7);
        tbl[12] = mk(0,0,1,16'h0010,0,26'h0,  32'h104, 32'h0,          32'h0,   0, 7);
        tbl[13] = mk(0,0,0,16'h0,   1,26'h55, 32'h104, 32'h0,          32'h0,   0, 7);
        tbl[14] = mk(1,0,0,16'h0,   0,26'h0,  32'h108, imem_f(32'h104),32'h108, 1, 8);

        // Reset takes effect without a clock edge
        rst_n_i = 1'b0;
        start_i = 0; stall_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_imm_i = '0; jump_idx_i = '0;
        #1;
        expect_state("reset", 32'h0, 32'h0, 32'h0, 0, 0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].start, tbl[i].stall, tbl[i].br, tbl[i].imm, tbl[i].jmp, tbl[i].idx);
            expect_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].pc4,
                         tbl[i].valid, tbl[i].cnt);
        end

        // Jump keeps the upper PC nibble of the ID instruction and beats a same-cycle branch
        do_reset();
        drive(1,0,0,16'h0,0,26'h0);
        drive(1,0,1,16'hFFFD,0,26'h0);
        expect_state("br_neg", 32'hFFFF_FFF8, 32'h0, 32'h0, 0, 1);
        drive(1,0,0,16'h0,0,26'h0);
        expect_state("hi_fetch", 32'hFFFF_FFFC, imem_f(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1, 2);
        drive(1,0,1,16'h0100,1,26'h40);
        expect_state("jmp_hi", 32'hF000_0100, 32'h0, 32'h0, 0, 2);
        drive(1,0,0,16'h0,0,26'h0);
        expect_state("jmp_tgt", 32'hF000_0104, imem_f(32'hF000_0100), 32'hF000_0104, 1, 3);

        // PC and PC+4 wrap past the top of the address space
        do_reset();
        drive(1,0,0,16'h0,0,26'h0);
        drive(1,0,1,16'hFFFE,0,26'h0);
        expect_state("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1);
        drive(1,0,0,16'h0,0,26'h0);
        expect_state("wrap", 32'h0, imem_f(32'hFFFF_FFFC), 32'h0, 1, 2);
        drive(1,0,0,16'h0,0,26'h0);
        expect_state("post_wrap", 32'h4, 32'h2008_0005, 32'h4, 1, 3);

        // Asynchronous reset between edges mid-run
        #2;
        rst_n_i = 1'b0;
        #1;
        expect_state("async_rst", 32'h0, 32'h0, 32'h0, 0, 0);
        do_reset();

        // Random run against the reference model
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            logic s, st, b, j;
            logic [15:0] im;
            logic [25:0] ix;
            s  = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 6) == 0);
            j  = ($urandom_range(0, 9) == 0);
            im = 16'($urandom);
            ix = 26'($urandom);
            model_step(s, st, b, im, j, ix);
            drive(s, st, b, im, j, ix);
            expect_state($sformatf("rnd%0d", i), m_pc, m_instr, m_pc4, m_valid, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
